// File: rtl/bp_burst_to_lite_if.sv
// Burst-in / Lite-out channel bundle for bp_burst_to_lite.
// slave : the converter (consumes Burst header/beats, produces the Lite message)
// master: the environment on the other side of the converter
interface bp_burst_to_lite_if
  #(parameter int in_msg_header_width_p = 67
    , parameter int in_data_width_p     = 64
    , parameter int out_msg_width_p     = 579
    );

  // Burst header channel
  logic [in_msg_header_width_p-1:0] in_msg_header_i;
  logic                             in_msg_header_v_i;
  logic                             in_msg_header_ready_and_o;

  // Burst data-beat channel
  logic [in_data_width_p-1:0]       in_msg_data_i;
  logic                             in_msg_data_v_i;
  logic                             in_msg_data_ready_and_o;
  logic                             in_msg_last_i;

  // Lite output channel, {header, data}
  logic [out_msg_width_p-1:0]       out_msg_o;
  logic                             out_msg_v_o;
  logic                             out_msg_ready_and_i;

  modport slave
    (input  in_msg_header_i, in_msg_header_v_i
     , output in_msg_header_ready_and_o
     , input  in_msg_data_i, in_msg_data_v_i, in_msg_last_i
     , output in_msg_data_ready_and_o
     , output out_msg_o, out_msg_v_o
     , input  out_msg_ready_and_i
     );

  modport master
    (output in_msg_header_i, in_msg_header_v_i
     , input  in_msg_header_ready_and_o
     , output in_msg_data_i, in_msg_data_v_i, in_msg_last_i
     , input  in_msg_data_ready_and_o
     , input  out_msg_o, out_msg_v_o
     , output out_msg_ready_and_i
     );

endinterface

// File: rtl/bp_burst_to_lite.sv
// bp_burst_to_lite: re-assembles one BedRock Burst message (header + data
// beats) into a single BedRock Lite message (header + full-width data).
// One message in flight: header, then beats, then the Lite output.
// Header layout (LSB first): msg_type[4], subop[4], addr[paddr], size[3], payload.
// Optional feature macro: BP_BURST_TO_LITE_LAST_CHECK_EN -- when defined, every
// beat's last flag is checked against the beat count and a mismatch sets the
// sticky err_o; when undefined err_o is tied low.
module bp_burst_to_lite
  #(parameter int          paddr_width_p    = 40
    , parameter int        in_data_width_p  = 64
    , parameter int        out_data_width_p = 512
    , parameter int        payload_width_p  = 16
    , parameter logic [15:0] payload_mask_p = 16'h0000
    )
   (input  logic            clk_i
    , input  logic          reset_n_i
    , bp_burst_to_lite_if.slave io
    , output logic          err_o
    );

  localparam int msg_type_width_lp      = 4;
  localparam int subop_width_lp         = 4;
  localparam int size_width_lp          = 3;
  localparam int addr_lsb_lp            = msg_type_width_lp + subop_width_lp;
  localparam int size_lsb_lp            = addr_lsb_lp + paddr_width_p;
  localparam int in_msg_header_width_lp = size_lsb_lp + size_width_lp + payload_width_p;
  localparam int out_msg_width_lp       = in_msg_header_width_lp + out_data_width_p;
  localparam int burst_words_lp         = out_data_width_p / in_data_width_p;
  localparam int bytes_per_beat_lp      = in_data_width_p / 8;
  localparam int cnt_width_lp           = (burst_words_lp > 1) ? $clog2(burst_words_lp) : 1;

  // Parameter sanity checks at elaboration
  if (out_data_width_p < in_data_width_p) begin : g_err_narrow
    $error("bp_burst_to_lite: out_data_width_p must be >= in_data_width_p");
  end
  if ((out_data_width_p % in_data_width_p) != 0) begin : g_err_multiple
    $error("bp_burst_to_lite: out_data_width_p must be a multiple of in_data_width_p");
  end
  if ((in_data_width_p % 8) != 0) begin : g_err_bytes
    $error("bp_burst_to_lite: in_data_width_p must be a multiple of 8");
  end

  typedef enum logic [1:0] {e_ready, e_data, e_send} state_e;

  state_e                              state_q, state_d;
  logic [in_msg_header_width_lp-1:0]   header_q, header_d;
  logic [out_data_width_p-1:0]         data_q, data_d;
  logic [cnt_width_lp-1:0]             cnt_q, cnt_d;

  logic hdr_hs, beat_hs, out_hs, final_hs, last_beat, has_data_in;
  logic [size_width_lp-1:0] size_q;
  logic [31:0]              beats_raw, exp_beats, exp_last;
  logic [cnt_width_lp-1:0]  rep_mask;

  assign hdr_hs   = io.in_msg_header_v_i & io.in_msg_header_ready_and_o;
  assign beat_hs  = io.in_msg_data_v_i & io.in_msg_data_ready_and_o;
  assign out_hs   = io.out_msg_v_o & io.out_msg_ready_and_i;

  assign has_data_in = payload_mask_p[io.in_msg_header_i[msg_type_width_lp-1:0]];
  assign size_q      = header_q[size_lsb_lp +: size_width_lp];

  // Beats expected for the registered header: bytes/beat-bytes, at least one, at most a full line
  always_comb begin
    beats_raw = (32'd1 << size_q) / 32'(bytes_per_beat_lp);
    exp_beats = beats_raw;
    if (beats_raw == 32'd0)
      exp_beats = 32'd1;
    else if (beats_raw > 32'(burst_words_lp))
      exp_beats = 32'(burst_words_lp);
    exp_last = exp_beats - 32'd1;
  end

  assign last_beat = (32'(cnt_q) == exp_last);
  assign final_hs  = beat_hs & last_beat;
  // Narrow transfers are power-of-two beats, so slice i replicates from slice (i mod beats)
  assign rep_mask  = exp_last[cnt_width_lp-1:0];

  // Per-slice view of the data register with the current beat merged in,
  // and the same view replicated for messages shorter than a full line.
  logic [in_data_width_p-1:0]  beat_fill [burst_words_lp];
  logic [out_data_width_p-1:0] data_fill, data_rep;

  for (genvar gi = 0; gi < burst_words_lp; gi++) begin : g_slice
    logic [cnt_width_lp-1:0] src_idx;
    assign beat_fill[gi] = (beat_hs && (cnt_q == cnt_width_lp'(gi)))
                           ? io.in_msg_data_i
                           : data_q[gi*in_data_width_p +: in_data_width_p];
    assign src_idx = cnt_width_lp'(gi) & rep_mask;
    assign data_fill[gi*in_data_width_p +: in_data_width_p] = beat_fill[gi];
    assign data_rep [gi*in_data_width_p +: in_data_width_p] = beat_fill[src_idx];
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)
      state_q <= e_ready;
    else
      state_q <= state_d;
  end

  // Next-state: header -> (beats) -> send -> back to ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_ready: if (hdr_hs)   state_d = has_data_in ? e_data : e_send;
      e_data:  if (final_hs) state_d = e_send;
      e_send:  if (out_hs)   state_d = e_ready;
      default:               state_d = e_ready;
    endcase
  end

  // Handshake outputs are pure functions of the state (no same-cycle bypass)
  always_comb begin
    io.in_msg_header_ready_and_o = 1'b0;
    io.in_msg_data_ready_and_o   = 1'b0;
    io.out_msg_v_o               = 1'b0;
    case (state_q)
      e_ready: io.in_msg_header_ready_and_o = 1'b1;
      e_data:  io.in_msg_data_ready_and_o   = 1'b1;
      e_send:  io.out_msg_v_o               = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: capture header, clear data, fill beats, replicate on the last one
  always_comb begin
    header_d = header_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    case (state_q)
      e_ready: begin
        if (hdr_hs) begin
          header_d = io.in_msg_header_i;
          data_d   = '0;
          cnt_d    = '0;
        end
      end
      e_data: begin
        if (beat_hs) begin
          if (final_hs) begin
            data_d = (exp_beats < 32'(burst_words_lp)) ? data_rep : data_fill;
            cnt_d  = '0;
          end else begin
            data_d = data_fill;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      header_q <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      header_q <= header_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign io.out_msg_o = {header_q, data_q};

`ifdef BP_BURST_TO_LITE_LAST_CHECK_EN
  logic err_q;

  // Sticky flag: the sender's last marker disagreed with the size-derived beat count
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)
      err_q <= 1'b0;
    else if (beat_hs && (io.in_msg_last_i != last_beat))
      err_q <= 1'b1;
  end

`ifndef SYNTHESIS
  // Report each mismatch with enough context to find the offending message
  always_ff @(posedge clk_i) begin
    if (reset_n_i && beat_hs && (io.in_msg_last_i != last_beat))
      $error("bp_burst_to_lite: last flag mismatch, msg_type %0d count %0d",
             header_q[msg_type_width_lp-1:0], cnt_q);
  end
`endif

  assign err_o = err_q;
`else
  logic unused_last;
  assign unused_last = io.in_msg_last_i;
  assign err_o       = 1'b0;
`endif

endmodule

// File: doc/bp_burst_to_lite.md
Name: bp_burst_to_lite

Overview:
- Converts a BedRock Burst message (header channel plus data-beat channel with last flag) into a single BedRock Lite message (header plus full-width data).
- Receive-side counterpart of the lite-to-burst converter: it sits at the network edge and re-assembles burst traffic for Lite-only consumers such as the UCE, cache-engine or memory adapters.
- Holds one message internally and serializes messages: header, then data beats, then the Lite output.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies paddr_width_p, lce_id_width_p, lce_assoc_p.
- in_data_width_p, "inv", Burst beat width in bits; must be a multiple of 8.
- out_data_width_p, "inv", Lite data width in bits; must be a multiple of in_data_width_p.
- payload_width_p, "inv", header payload width.
- payload_mask_p, 0, bitmask: bit t set means msg_type t carries data.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous, active-low reset.
- in_msg_header_i  in  in_msg_header_width_lp  Burst header.
- in_msg_header_v_i  in  1  header valid.
- in_msg_header_ready_and_o  out  1  header ready (ready-valid-and).
- in_msg_data_i  in  in_data_width_p  data beat.
- in_msg_data_v_i  in  1  beat valid.
- in_msg_data_ready_and_o  out  1  beat ready (ready-valid-and).
- in_msg_last_i  in  1  final beat of the burst.
- out_msg_o  out  out_msg_width_lp  Lite message, {header, data}.
- out_msg_v_o  out  1  Lite valid.
- out_msg_ready_and_i  in  1  Lite ready (ready-valid-and).
- err_o  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset: state e_ready, beat counter 0, header and data registers 0. Every output is 0 except in_msg_header_ready_and_o, which is 1.
- State e_ready: in_msg_header_ready_and_o=1, in_msg_data_ready_and_o=0.
  - On header handshake, register the header.
  - has_data = payload_mask_p[msg_type]. If has_data, go to e_data; otherwise go to e_send.
- Beat count and counter width:
  - expected_beats = max(1, (1<<size)/(in_data_width_p/8)), clamped to burst_words = out_data_width_p/in_data_width_p.
  - Counter width is safe_clog2(burst_words).
- State e_data: in_msg_data_ready_and_o=1, header ready=0.
  - Beat k is written to data slice [k*in_data_width_p +: in_data_width_p].
  - The counter increments per handshake.
  - On the handshake with count == expected_beats-1, go to e_send and clear the counter. in_msg_last_i is not used for control.
- Replication: on the transition into e_send, when expected_beats < burst_words, the filled low expected_beats slices are replicated across the full out_data_width_p. Narrow data therefore appears at every aligned position, matching Lite replication.
- State e_send: out_msg_v_o=1 and both input ready outputs are 0.
  - Header and data are held stable until out_msg_ready_and_i.
  - On handshake, go to e_ready.
  - Header ready rises the cycle after the handshake; there is no same-cycle bypass.
- Data-less message: data field outputs 0.
- Latency:
  - Data-less: header accepted in cycle N gives out_msg_v_o in N+1.
  - With data: final beat accepted in cycle M gives out_msg_v_o in M+1.
  - Peak throughput is one message every 2+expected_beats cycles.
- Simultaneous events:
  - A beat that is valid in the same cycle as its header is not accepted until the next cycle.
  - Beats presented during e_ready or e_send are stalled, not dropped.
- Reset mid-operation: a partial burst or an un-acked output is discarded, and the block returns to the reset state on the next edge.
- Elaboration asserts:
  - out_data_width_p >= in_data_width_p.
  - out_data_width_p % in_data_width_p == 0.

Optional Feature:
- Macro: BP_BURST_TO_LITE_LAST_CHECK_EN.
- Defined: on every beat handshake, compare in_msg_last_i with (count == expected_beats-1).
  - A mismatch sets err_o; err_o is sticky until reset.
  - A simulation $error prints the msg_type and the count.
  - Data flow is unchanged.
- Undefined: err_o is tied to 0, with no comparison logic and no error message.

Test Plan (in_data_width_p=64, out_data_width_p=512, write msg_type in payload_mask_p):
- Read header (no data), size=64B, ready held high: Lite valid the cycle after the header handshake; data==0; header ready returns the cycle after the Lite handshake.
- Write header, size=64B, beats 0x0..0x7 with last on beat 7: data slice k==k; out_msg_v_o exactly one cycle after beat 7; the header matches the input.
- Write header, size=8B, one beat 0xDEADBEEF_CAFEF00D: all 8 slices equal that value; the counter returns to 0.
- Write header, size=16B, beats A,B: data is the pattern {B,A} repeated 4 times.
- Backpressure:
  - out_msg_ready_and_i low for 5 cycles: output stays stable, both input ready outputs stay 0, and a queued next header is accepted one cycle after release.
  - Beats with random valid gaps: assembly is still correct.
- reset_n_i low for 1 cycle after beat 3 of an 8-beat burst: the next cycle shows state e_ready, out_msg_v_o=0 and header ready=1; a fresh 8-beat burst then assembles correctly.
- With BP_BURST_TO_LITE_LAST_CHECK_EN defined, last asserted on beat 2 of an 8-beat burst: err_o=1 from the next cycle and stays 1; the message completes after beat 7.
